// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority oversampling,
// LSB-first deserialisation and frame sequencing around an external parity checker.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int                   BIT_W    = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]     BIT_ONE  = 1;
  localparam logic [PRESC_W-1:0]   CNT_ONE  = 1;

  state_t               state, state_nxt;
  logic [PRESC_W-1:0]   edge_cnt;
  logic [PRESC_W-1:0]   p_lat;
  logic [PRESC_W-1:0]   half;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 s0, s1;
  logic                 par_flag;
  logic                 bit_end;
  logic                 shift_en;
  logic                 strt_nxt, stp_nxt, dv_nxt;

  assign half    = p_lat >> 1;
  assign bit_end = (edge_cnt == p_lat - CNT_ONE);
  assign rx_busy = (state != IDLE);

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    strt_nxt   = 1'b0;
    stp_nxt    = 1'b0;
    dv_nxt     = 1'b0;
    par_chk_en = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: if (!RX_IN) state_nxt = START;
      START: if (bit_end) begin
        if (sampled_bit) begin
          strt_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: if (bit_end) begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        par_chk_en = 1'b1;
        state_nxt  = STOP;
      end
      STOP: if (bit_end) begin
        // A bad stop bit masks any parity failure.
        if (!sampled_bit)   stp_nxt = 1'b1;
        else if (!par_flag) dv_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      p_lat       <= '0;
      bit_cnt     <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b0;
      par_flag    <= 1'b0;
      P_DATA      <= '0;
      strt_glitch <= 1'b0;
      stp_err     <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      strt_glitch <= strt_nxt;
      stp_err     <= stp_nxt;
      data_valid  <= dv_nxt;

      // The IDLE cycle that sees the start edge is edge 0 of the start bit.
      if (state == IDLE) begin
        edge_cnt <= RX_IN ? '0 : CNT_ONE;
        if (!RX_IN) p_lat <= Prescale;
      end else begin
        edge_cnt <= bit_end ? '0 : edge_cnt + CNT_ONE;
        if (edge_cnt == half - CNT_ONE) s0 <= RX_IN;
        if (edge_cnt == half)           s1 <= RX_IN;
        if (edge_cnt == half + CNT_ONE)
          sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
      end

      if (state == START && bit_end) bit_cnt <= '0;
      if (shift_en) begin
        P_DATA  <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BIT_ONE;
      end

      if (par_chk_en)                     par_flag <= par_err;
      else if (state == STOP && bit_end)  par_flag <= 1'b0;
    end
  end

endmodule
